// File: rtl/kbd_pkg.sv
// ---------------------------------------------------------------------------
// kbd_pkg
// Shared types and default geometry for the matrix keyboard scanner.
//   KBD_NROWS / KBD_NCOLS : default matrix size
//   key_code_t            : key code, row*NCOLS+col
//   kbd_frame_t           : one bit per key for a full matrix snapshot
//   kbd_state_t           : scanner FSM states
// ---------------------------------------------------------------------------
package kbd_pkg;
   localparam int KBD_NROWS = 4;
   localparam int KBD_NCOLS = 4;
   localparam int KBD_NKEYS = KBD_NROWS * KBD_NCOLS;
   localparam int KBD_KEY_W = $clog2(KBD_NKEYS);

   typedef logic [KBD_KEY_W-1:0] key_code_t;
   typedef logic [KBD_NKEYS-1:0] kbd_frame_t;

   typedef enum logic {
      SCAN = 1'b0,
      EVAL = 1'b1
   } kbd_state_t;
endpackage

// File: rtl/sync_edge.sv
// ---------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizers for an edge-detected async strobe plus a bus of
// async level signals.
//   i_clk, i_rst_n  : system clock, async active-low reset
//   i_edge_async    : async strobe whose rising edge produces o_tick
//   i_level_async   : async levels, only synchronized
//   o_level         : synchronized levels (reset to LEVEL_RST)
//   o_tick          : 1-cycle pulse, registered, 3 clocks after the strobe rises
// ---------------------------------------------------------------------------
module sync_edge #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] LEVEL_RST = '0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_edge_async,
   input  logic [WIDTH-1:0] i_level_async,
   output logic [WIDTH-1:0] o_level,
   output logic             o_tick
);
   logic             r_edge_ff1;
   logic             r_edge_ff2;
   logic             r_edge_prev;
   logic             r_tick;
   logic [WIDTH-1:0] r_lvl_ff1;
   logic [WIDTH-1:0] r_lvl_ff2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_edge_ff1  <= 1'b0;
         r_edge_ff2  <= 1'b0;
         r_edge_prev <= 1'b0;
         r_tick      <= 1'b0;
         r_lvl_ff1   <= LEVEL_RST;
         r_lvl_ff2   <= LEVEL_RST;
      end else begin
         r_edge_ff1  <= i_edge_async;
         r_edge_ff2  <= r_edge_ff1;
         r_edge_prev <= r_edge_ff2;
         // Registered so the pulse lands exactly 3 clocks after the async edge.
         r_tick      <= r_edge_ff2 & ~r_edge_prev;
         r_lvl_ff1   <= i_level_async;
         r_lvl_ff2   <= r_lvl_ff1;
      end
   end

   assign o_level = r_lvl_ff2;
   assign o_tick  = r_tick;
endmodule

// File: rtl/matrix_kbd_scan.sv
// ---------------------------------------------------------------------------
// matrix_kbd_scan
// Scans an NROWS x NCOLS passive key matrix, debounces whole-matrix frames
// and reports the lowest-index pressed key.
//   clk_i       : system clock
//   rst_ni      : async active-low reset
//   scan_clk_i  : slow scan strobe; each rising edge steps one column
//   row_i       : raw rows, active-low (low = key closed)
//   col_o       : column drive, active-low one-hot
//   key_o       : committed key code, row*NCOLS+col
//   valid_o     : 1-cycle pulse when a new key code is committed
//   pressed_o   : level, at least one key in the debounced state
// ---------------------------------------------------------------------------
module matrix_kbd_scan
   import kbd_pkg::*;
#(
   parameter int NROWS           = KBD_NROWS,
   parameter int NCOLS           = KBD_NCOLS,
   parameter int DEBOUNCE_FRAMES = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             scan_clk_i,
   input  logic [NROWS-1:0]                 row_i,
   output logic [NCOLS-1:0]                 col_o,
   output logic [$clog2(NROWS*NCOLS)-1:0]   key_o,
   output logic                             valid_o,
   output logic                             pressed_o
);
   localparam int NKEYS = NROWS * NCOLS;
   localparam int KEY_W = $clog2(NKEYS);
   localparam int COL_W = $clog2(NCOLS);
   localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOLS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

   logic             w_tick;
   logic [NROWS-1:0] w_row_sync;

   kbd_state_t       r_state;
   kbd_state_t       w_state_next;
   logic             w_scan_en;
   logic             w_eval_en;

   logic [COL_W-1:0] r_col;
   logic [NKEYS-1:0] r_cur_frame;
   logic [NKEYS-1:0] w_cur_frame_next;
   logic [NKEYS-1:0] r_last_frame;
   logic [NKEYS-1:0] r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_commit;
   logic             r_commit;
   logic [KEY_W-1:0] w_code;

   logic [KEY_W-1:0] r_key;
   logic             r_valid;
   logic             r_pressed;

   // Rows idle high, so their synchronizer resets to "no key".
   sync_edge #(
      .WIDTH     (NROWS),
      .LEVEL_RST ('1)
   ) u_sync (
      .i_clk         (clk_i),
      .i_rst_n       (rst_ni),
      .i_edge_async  (scan_clk_i),
      .i_level_async (row_i),
      .o_level       (w_row_sync),
      .o_tick        (w_tick)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= SCAN;
      else         r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         SCAN: if (w_tick && (r_col == LAST_COL)) w_state_next = EVAL;
         EVAL: w_state_next = SCAN;
         default: w_state_next = SCAN;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_scan_en = (r_state == SCAN) && w_tick;
      w_eval_en = (r_state == EVAL);
   end

   // Current column's bits take the inverted (active-high) row levels.
   always_comb begin
      w_cur_frame_next = r_cur_frame;
      for (int k = 0; k < NKEYS; k++) begin
         if (COL_W'(k % NCOLS) == r_col) w_cur_frame_next[k] = ~w_row_sync[k / NCOLS];
      end
   end

   // Debounce count after this EVAL; a differing frame restarts at 1.
   always_comb begin
      if (r_cur_frame != r_last_frame) w_cnt_next = CNT_W'(1);
      else if (r_cnt == CNT_MAX)       w_cnt_next = CNT_MAX;
      else                             w_cnt_next = r_cnt + CNT_W'(1);
      w_commit = (w_cnt_next == CNT_MAX);
   end

   // Lowest set index wins: scan downward so the last hit is the lowest.
   always_comb begin
      w_code = '0;
      for (int k = NKEYS - 1; k >= 0; k--) begin
         if (r_stable[k]) w_code = KEY_W'(k);
      end
   end

   // Scan / debounce datapath.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_col        <= '0;
         r_cur_frame  <= '0;
         r_last_frame <= '0;
         r_stable     <= '0;
         r_cnt        <= '0;
         r_commit     <= 1'b0;
      end else begin
         r_commit <= 1'b0;
         if (w_scan_en) begin
            r_cur_frame <= w_cur_frame_next;
            r_col       <= (r_col == LAST_COL) ? '0 : r_col + COL_W'(1);
         end
         if (w_eval_en) begin
            // After EVAL last_frame always equals cur_frame, changed or not.
            r_last_frame <= r_cur_frame;
            r_cnt        <= w_cnt_next;
            if (w_commit) begin
               r_stable <= r_cur_frame;
               r_commit <= 1'b1;
            end
         end
      end
   end

   // Output update, one cycle after a commit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_key     <= '0;
         r_valid   <= 1'b0;
         r_pressed <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_commit) begin
            r_pressed <= |r_stable;
            if (|r_stable) begin
               r_key   <= w_code;
               r_valid <= !r_pressed || (w_code != r_key);
            end
         end
      end
   end

   always_comb begin
      col_o        = '1;
      col_o[r_col] = 1'b0;
   end

   assign key_o     = r_key;
   assign valid_o   = r_valid;
   assign pressed_o = r_pressed;
endmodule

// File: tb/tb_matrix_kbd_scan.sv
module tb_matrix_kbd_scan;
  localparam time CLK_P     = 40ns;
  localparam time SCAN_HALF = 400ns;   // scan period = 20 clocks
  localparam int  FRAME     = 80;      // 4 columns x 20 clocks

  logic        clk;
  logic        rst_n;
  logic        scan_clk;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic [3:0]  key_o;
  logic        valid_o;
  logic        pressed_o;
  logic [15:0] keys;

  logic [3:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  matrix_kbd_scan dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scan_clk_i (scan_clk),
    .row_i      (row_i),
    .col_o      (col_o),
    .key_o      (key_o),
    .valid_o    (valid_o),
    .pressed_o  (pressed_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #(CLK_P / 2) clk = ~clk;
  end

  initial begin
    scan_clk = 1'b0;
    #13ns;
    forever #(SCAN_HALF) scan_clk = ~scan_clk;
  end

  // Key matrix model: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row_i = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_o[c] && keys[r*4+c]) row_i[r] = 1'b0;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge right after col_o wraps back to column 0.
  task automatic sync_frame();
    logic [3:0] prev;
    bit found = 0;
    prev = col_o;
    for (int t = 0; t < 400 && !found; t++) begin
      @(negedge clk);
      if (col_o == 4'b1110 && prev != 4'b1110) found = 1;
      prev = col_o;
    end
    check("frame_sync", found, 1);
  endtask

  task automatic expect_col_step(input logic [3:0] exp);
    logic [3:0] prev;
    bit changed = 0;
    prev = col_o;
    for (int t = 0; t < 100 && !changed; t++) begin
      @(negedge clk);
      if (col_o != prev) changed = 1;
    end
    check("col_step", col_o, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: key_o=%0d but no pulse expected at %0t", key_o, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("valid_key", key_o, e);
        check("valid_pressed", pressed_o, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0] col_seq [4];

  initial begin
    col_seq[0] = 4'b1101; col_seq[1] = 4'b1011; col_seq[2] = 4'b0111; col_seq[3] = 4'b1110;
    rst_n = 1'b0;
    keys  = '0;
    wait_cycles(5);
    check("rst_col", col_o, 4'b1110);
    check("rst_key", key_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_pressed", pressed_o, 0);
    rst_n = 1'b1;

    // 1: idle scanning
    for (int i = 0; i < 8; i++) expect_col_step(col_seq[i % 4]);
    wait_cycles(18 * FRAME);
    check("idle_pressed", pressed_o, 0);

    // 2: clean press of r2c1
    sync_frame();
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_cycles(3 * FRAME + 40);
    check("t2_before_commit", pressed_o, 0);
    wait_cycles(60);
    check("t2_pressed", pressed_o, 1);
    check("t2_key", key_o, 9);
    wait_cycles(2 * FRAME);

    sync_frame();
    keys = '0;
    wait_cycles(7 * FRAME);
    check("t2_release", pressed_o, 0);

    // 3: bouncing then stable
    sync_frame();
    for (int i = 0; i < 3; i++) begin
      keys[9] = 1'b1;
      wait_cycles(FRAME);
      keys[9] = 1'b0;
      wait_cycles(FRAME);
    end
    check("t3_no_commit_bounce", pressed_o, 0);
    keys[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_cycles(3 * FRAME + 40);
    check("t3_before_commit", pressed_o, 0);
    wait_cycles(60);
    check("t3_pressed", pressed_o, 1);
    check("t3_key", key_o, 9);

    // 4: multi-key priority
    sync_frame();
    keys = '0;
    keys[3] = 1'b1;
    exp_q.push_back(4'd3);
    wait_cycles(7 * FRAME);
    check("t4_key3", key_o, 3);
    keys[12] = 1'b1;
    wait_cycles(7 * FRAME);
    check("t4_add12_key", key_o, 3);
    check("t4_add12_pressed", pressed_o, 1);
    keys[3] = 1'b0;
    exp_q.push_back(4'd12);
    wait_cycles(7 * FRAME);
    check("t4_key12", key_o, 12);

    // 5: release all, then re-press
    sync_frame();
    keys = '0;
    wait_cycles(2 * FRAME + 40);
    check("t5_still_pressed", pressed_o, 1);
    wait_cycles(5 * FRAME);
    check("t5_released", pressed_o, 0);
    check("t5_key_kept", key_o, 12);
    keys[12] = 1'b1;
    exp_q.push_back(4'd12);
    wait_cycles(7 * FRAME);
    check("t5_repress", pressed_o, 1);

    // 6: async reset mid-frame with key held
    sync_frame();
    wait_cycles(30);
    #7ns;
    rst_n = 1'b0;
    #1ns;
    check("t6_col", col_o, 4'b1110);
    check("t6_key", key_o, 0);
    check("t6_valid", valid_o, 0);
    check("t6_pressed", pressed_o, 0);
    wait_cycles(3);
    rst_n = 1'b1;
    exp_q.push_back(4'd12);
    wait_cycles(7 * FRAME);
    check("t6_recommit_pressed", pressed_o, 1);
    check("t6_recommit_key", key_o, 12);

    wait_cycles(10);
    check("pulses_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
